// File: rtl/counter_pkg.sv
// Shared types and constants for the histogram accumulator memory.
// Optional saturation is selected by COUNTER_HIST_SAT_EN in counter_hist_ram.
package counter_pkg;

    localparam int FLUSH_CYCLES = 2;

    // Forwarding record fields are sized for widths up to 32 bits.
    localparam int FWD_WIDTH = 32;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_FLUSH,
        CLR_CLEAR
    } clr_state_t;

    typedef struct packed {
        logic                 valid;
        logic [FWD_WIDTH-1:0] addr;
        logic [FWD_WIDTH-1:0] data;
    } fwd_rec_t;

endpackage

// File: rtl/counter_sram.sv
// Dual-port counter RAM with read-first registered outputs.
// Port A has split read/write addresses for the increment pipeline.
module counter_sram #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4096
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [ADDR_WIDTH-1:0] a_raddr,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_waddr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_we,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic [DATA_WIDTH-1:0] b_rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_we) mem[a_waddr] <= a_wdata;
        if (b_we) mem[b_addr] <= b_wdata;
    end

    // Reads sample the array before this edge's writes land.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            a_rdata <= mem[a_raddr];
            b_rdata <= mem[b_addr];
        end
    end

endmodule

// File: rtl/counter_hist_ram.sv
// Histogram accumulator: two-stage read-modify-write increment with forwarding,
// host read port, sweep-clear engine, overflow flag. COUNTER_HIST_SAT_EN selects saturation.
module counter_hist_ram
    import counter_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 4096,
    parameter int INC_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_inc_valid,
    input  logic [ADDR_WIDTH-1:0] i_inc_addr,
    input  logic [INC_WIDTH-1:0]  i_inc_amount,
    input  logic                  i_clr_start,
    output logic                  o_clr_busy,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_valid,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_ovf,
    input  logic                  i_ovf_clr
);

    localparam int SUM_WIDTH = FWD_WIDTH + 1;

    clr_state_t            state;
    clr_state_t            state_next;
    logic [1:0]            flush_cnt;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  busy;

    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic [INC_WIDTH-1:0]  s1_amount;
    logic                  s2_valid;
    logic [ADDR_WIDTH-1:0] s2_addr;
    logic [INC_WIDTH-1:0]  s2_amount;
    fwd_rec_t              fwd;

    logic                  forward_hit;
    logic [FWD_WIDTH-1:0]  old_val;
    logic [SUM_WIDTH-1:0]  sum;
    logic                  carry;
    logic [DATA_WIDTH-1:0] wr_data;

    logic [DATA_WIDTH-1:0] ram_a_rdata;
    logic [ADDR_WIDTH-1:0] ram_b_addr;
    logic                  ram_b_we;

    assign busy       = (state != CLR_IDLE);
    assign o_clr_busy = busy;

    // Reset lands in CLEAR so the memory is always swept after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state     <= CLR_CLEAR;
            flush_cnt <= '0;
            clr_addr  <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= (state == CLR_FLUSH) ? flush_cnt + 2'd1 : 2'd0;
            clr_addr  <= (state == CLR_CLEAR) ? clr_addr + ADDR_WIDTH'(1) : '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLR_IDLE:  if (i_clr_start) state_next = CLR_FLUSH;
            CLR_FLUSH: if (flush_cnt == 2'(FLUSH_CYCLES - 1)) state_next = CLR_CLEAR;
            CLR_CLEAR: if (clr_addr == ADDR_WIDTH'(DEPTH - 1)) state_next = CLR_IDLE;
            default:   state_next = CLR_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        s1_addr   <= i_inc_addr;
        s1_amount <= i_inc_amount;
        s2_addr   <= s1_addr;
        s2_amount <= s1_amount;
    end

    // The forwarding record covers the one write the RAM read cannot yet see.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            fwd        <= '0;
            o_rd_valid <= 1'b0;
            o_ovf      <= 1'b0;
        end else begin
            s1_valid   <= i_inc_valid && !busy;
            s2_valid   <= s1_valid;
            fwd.valid  <= s2_valid;
            fwd.addr   <= FWD_WIDTH'(s2_addr);
            fwd.data   <= FWD_WIDTH'(wr_data);
            o_rd_valid <= i_rd_en && !busy;
            if (s2_valid && carry)
                o_ovf <= 1'b1;
            else if (i_ovf_clr)
                o_ovf <= 1'b0;
        end
    end

    always_comb begin
        forward_hit = fwd.valid && (fwd.addr == FWD_WIDTH'(s2_addr));
        old_val     = forward_hit ? fwd.data : FWD_WIDTH'(ram_a_rdata);
        sum         = {1'b0, old_val} + SUM_WIDTH'(s2_amount);
        carry       = |sum[SUM_WIDTH-1:DATA_WIDTH];
`ifdef COUNTER_HIST_SAT_EN
        wr_data     = carry ? '1 : sum[DATA_WIDTH-1:0];
`else
        wr_data     = sum[DATA_WIDTH-1:0];
`endif
    end

    assign ram_b_we   = (state == CLR_CLEAR);
    assign ram_b_addr = ram_b_we ? clr_addr : i_rd_addr;

    counter_sram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_sram (
        .clk     (i_clk),
        .rstn    (i_rstn),
        .a_raddr (s1_addr),
        .a_rdata (ram_a_rdata),
        .a_we    (s2_valid),
        .a_waddr (s2_addr),
        .a_wdata (wr_data),
        .b_addr  (ram_b_addr),
        .b_we    (ram_b_we),
        .b_wdata ('0),
        .b_rdata (o_rd_data)
    );

endmodule

// File: tb/tb_counter_hist_ram.sv
// Self-checking bench for counter_hist_ram against an array model of the bins;
// expectations follow COUNTER_HIST_SAT_EN when defined.
module tb_counter_hist_ram;

    localparam int ADDR_WIDTH = 12;
    localparam int DATA_WIDTH = 18;
    localparam int DEPTH      = 4096;
    localparam int INC_WIDTH  = 8;
    localparam longint unsigned MAX_VAL = (longint'(1) << DATA_WIDTH) - 1;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  inc_valid;
    logic [ADDR_WIDTH-1:0] inc_addr;
    logic [INC_WIDTH-1:0]  inc_amount;
    logic                  clr_start;
    logic                  clr_busy;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ovf;
    logic                  ovf_clr;

    int checks = 0;
    int errors = 0;
    longint unsigned model [DEPTH];
    bit ovf_model;

    counter_hist_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .INC_WIDTH  (INC_WIDTH)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_inc_valid  (inc_valid),
        .i_inc_addr   (inc_addr),
        .i_inc_amount (inc_amount),
        .i_clr_start  (clr_start),
        .o_clr_busy   (clr_busy),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .o_rd_valid   (rd_valid),
        .o_rd_data    (rd_data),
        .o_ovf        (ovf),
        .i_ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // A bin's new value follows the wrap or clamp rule; any carry raises the flag.
    task automatic modelAdd(input int a, input int amt);
        longint unsigned s;
        s = model[a] + longint'(amt);
        if (s > MAX_VAL) begin
            ovf_model = 1'b1;
`ifdef COUNTER_HIST_SAT_EN
            s = MAX_VAL;
`else
            s = s - (MAX_VAL + 1);
`endif
        end
        model[a] = s;
    endtask

    task automatic applyStimulus(input bit v, input int a, input int amt,
                                 input bit rd, input int ra, input bit track);
        inc_valid  = v;
        inc_addr   = ADDR_WIDTH'(a);
        inc_amount = INC_WIDTH'(amt);
        rd_en      = rd;
        rd_addr    = ADDR_WIDTH'(ra);
        if (track && v) modelAdd(a, amt);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic hostRead(input int a);
        applyStimulus(0, 0, 0, 1, a, 0);
        checkOutput($sformatf("rd_valid_bin%0d", a), {31'd0, rd_valid}, 32'd1);
        checkOutput($sformatf("rd_data_bin%0d", a), {14'd0, rd_data}, model[a][31:0]);
    endtask

    task automatic preload(input int a, input longint unsigned target);
        longint unsigned rem;
        while (model[a] < target) begin
            rem = target - model[a];
            applyStimulus(1, a, (rem > 255) ? 255 : int'(rem), 0, 0, 1);
        end
        idle(3);
    endtask

    // Counts cycles with busy high; optionally hammers requests and a second start pulse.
    task automatic waitClearDone(input bit noisy, output int cnt);
        cnt = 0;
        while (clr_busy && cnt < 10000) begin
            cnt++;
            if (noisy && (cnt % 1024 == 2))
                checkOutput("busy_rd_valid", {31'd0, rd_valid}, 32'd0);
            clr_start = noisy && (cnt == 50);
            if (noisy)
                applyStimulus($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255),
                              1, $urandom_range(0, 7), 0);
            else
                applyStimulus(0, 0, 0, 0, 0, 0);
        end
        clr_start = 1'b0;
        rd_en     = 1'b0;
        inc_valid = 1'b0;
    endtask

    initial begin
        int cnt;
        rstn      = 1'b0;
        inc_valid = 1'b0;
        inc_addr  = '0;
        inc_amount = '0;
        clr_start = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        ovf_clr   = 1'b0;
        ovf_model = 1'b0;
        foreach (model[i]) model[i] = 0;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", {31'd0, clr_busy}, 32'd1);
        checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        checkOutput("rst_rd_data", {14'd0, rd_data}, 32'd0);
        checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
        rstn = 1'b1;
        waitClearDone(0, cnt);
        checkOutput("rst_clear_cycles", cnt, DEPTH);
        for (int i = 0; i < 4; i++) hostRead(i);

        $display("[TB] back-to-back increments on bin 5");
        for (int i = 0; i < 10; i++) applyStimulus(1, 5, 1, 0, 0, 1);
        idle(3);
        hostRead(5);
        checkOutput("bin5_total", model[5][31:0], 32'd10);

        $display("[TB] interleaved increments on bins 3 and 4");
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) applyStimulus(1, 3, 2, 0, 0, 1);
            else            applyStimulus(1, 4, 7, 0, 0, 1);
        end
        idle(3);
        hostRead(3);
        hostRead(4);

        $display("[TB] overflow on bin 0");
        preload(0, MAX_VAL - 1);
        hostRead(0);
        checkOutput("ovf_before", {31'd0, ovf}, 32'd0);
        applyStimulus(1, 0, 5, 0, 0, 1);
        idle(1);
        ovf_clr = 1'b1;
        idle(1);
        checkOutput("ovf_set_wins", {31'd0, ovf}, 32'd1);
        idle(1);
        ovf_clr = 1'b0;
        ovf_model = 1'b0;
        checkOutput("ovf_cleared", {31'd0, ovf}, 32'd0);
        hostRead(0);

        $display("[TB] random increments");
        for (int i = 0; i < 300; i++)
            applyStimulus($urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255), 0, 0, 1);
        idle(3);
        for (int i = 0; i < 8; i++) hostRead(i);
        checkOutput("ovf_random", {31'd0, ovf}, {31'd0, ovf_model});

        $display("[TB] clear while increments stream");
        for (int i = 0; i < 5; i++)
            applyStimulus(1, $urandom_range(0, 7), $urandom_range(1, 255), 0, 0, 1);
        clr_start = 1'b1;
        applyStimulus(1, $urandom_range(0, 7), $urandom_range(1, 255), 0, 0, 1);
        clr_start = 1'b0;
        waitClearDone(1, cnt);
        checkOutput("clr_busy_cycles", cnt, DEPTH + 2);
        foreach (model[i]) model[i] = 0;
        for (int i = 0; i < 8; i++) hostRead(i);
        hostRead(DEPTH - 1);

        $display("[TB] reset during clear");
        preload(9, MAX_VAL - 1);
        applyStimulus(1, 9, 5, 0, 0, 1);
        idle(3);
        checkOutput("ovf_pre_rst", {31'd0, ovf}, 32'd1);
        hostRead(9);
        clr_start = 1'b1;
        idle(1);
        clr_start = 1'b0;
        idle(102);
        rstn = 1'b0;
        idle(1);
        checkOutput("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        checkOutput("midrst_ovf", {31'd0, ovf}, 32'd0);
        checkOutput("midrst_busy", {31'd0, clr_busy}, 32'd1);
        rstn = 1'b1;
        ovf_model = 1'b0;
        waitClearDone(0, cnt);
        checkOutput("midrst_clear_cycles", cnt, DEPTH);
        foreach (model[i]) model[i] = 0;
        hostRead(9);
        hostRead(200);
        hostRead(DEPTH - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_hist_ram.md
# counter_hist_ram

Histogram accumulator memory for the counter project: a parametrised successor to the plain dual-port counter SRAM that adds an internal read-modify-write increment port with hazard forwarding, a host read port, an automatic sweep-clear engine and overflow detection. It sits between the counter's bin-address generator (increment side) and the register/bus interface (read side). One increment per clock is sustained at full rate, including back-to-back hits on the same bin.

## Interface
- ADDR_WIDTH, 12, bin address width
- DATA_WIDTH, 18, counter width per bin
- DEPTH, 4096, number of bins; must be ≤ 2**ADDR_WIDTH
- INC_WIDTH, 8, increment amount width; must be ≤ DATA_WIDTH

Ports:
- i_clk  in  1  single clock
- i_rstn  in  1  reset, synchronous, active-low
- i_inc_valid  in  1  increment request
- i_inc_addr  in  ADDR_WIDTH  bin to increment
- i_inc_amount  in  INC_WIDTH  unsigned amount added
- i_clr_start  in  1  one-cycle pulse to start a full clear
- o_clr_busy  out  1  clear in progress; reset value 1
- i_rd_en  in  1  host read request
- i_rd_addr  in  ADDR_WIDTH  host read address
- o_rd_valid  out  1  o_rd_data valid; reset value 0
- o_rd_data  out  DATA_WIDTH  bin value; reset value 0
- o_ovf  out  1  sticky overflow flag; reset value 0
- i_ovf_clr  in  1  clears o_ovf

## Operation
- RAM: true dual-port, registered read-first output, 1-cycle read latency. Port A is owned by the increment pipeline; port B by the host read and clear engine.
- Increment pipeline, stage S1: accept when i_inc_valid && !o_clr_busy, and issue the port-A read. Stage S2, next cycle: old = forward_hit ? last_wr_data : ram_dout; sum = old + amount; write at the end of S2.
- Forwarding register holds the address and data of the previous cycle's write. forward_hit = last_wr_valid && last_wr_addr == S2 addr. Back-to-back same-address increments therefore accumulate correctly.
- Arithmetic: sum is computed DATA_WIDTH+1 bits wide with amount zero-extended. Result handling depends on the macro (see Configuration).
- o_ovf is set on overflow and cleared by i_ovf_clr. If both happen in the same cycle, set wins.
- Host read: o_rd_valid = i_rd_en registered, and o_rd_data is the port-B output.
  - i_rd_en is ignored while o_clr_busy; o_rd_valid stays 0.
  - A read of a bin with an in-flight increment returns the pre-increment value. This is documented, not a bug.
- Clear FSM (enum):
  - IDLE: i_clr_start → FLUSH.
  - FLUSH: wait 2 cycles for S1/S2 to drain → CLEAR.
  - CLEAR: write 0 at clr_addr via port B, clr_addr 0..DEPTH-1 one per cycle; after the last address → IDLE.
- o_clr_busy = (state != IDLE). i_clr_start is ignored while busy.
- i_inc_valid while busy: the request is dropped, not queued.
- Reset: FSM enters CLEAR with clr_addr=0, so memory is zeroed after every reset. The pipeline valids and forwarding valid clear, and in-flight increments are lost.
- Reset asserted mid-clear restarts the clear at address 0.

## Timing
- Increment accepted at edge t: RAM is written at edge t+2 and the value is host-visible for a read issued at cycle t+2 or later.
- Host read: i_rd_en at edge t → o_rd_valid/o_rd_data at edge t+1.
- Clear after pulse: o_clr_busy rises at the next edge and is held for 2+DEPTH cycles.
- Clear after reset release: DEPTH cycles.
- Throughput: 1 increment/cycle, 1 host read/cycle, concurrently.
- Port conflict: an increment write and a host read to the same address in the same cycle are legal; the read returns the old value.

## Configuration
- COUNTER_HIST_SAT_EN defined: sum is clamped to all-ones when the carry bit is set, and o_ovf is set. A bin never wraps.
- Not defined: sum wraps modulo 2**DATA_WIDTH, and o_ovf is set on carry-out.

## Structure
- Package counter_pkg holds:
  - the clear-state enum (CLR_IDLE, CLR_FLUSH, CLR_CLEAR)
  - the FLUSH_CYCLES=2 constant
  - a typedef for the forwarding record {valid, addr, data}
- Sub-module: counter_sram (existing dual-port RAM), instantiated once with the block's ADDR_WIDTH/DATA_WIDTH/DEPTH. The FSM, pipeline and forwarding live in counter_hist_ram.

## Test plan
- Reset, wait 4096 cycles, read bins 0..3 → all 0, o_clr_busy=0 after exactly DEPTH cycles.
- Increment bin 5 by 1 on 10 consecutive cycles, then read bin 5 → 10, confirming the forwarding path.
- Interleave increments A=3 (+2) and A=4 (+7), alternating for 8 cycles; read → bin3=8, bin4=28.
- Preload bin 0 to 2**18-2, then add 5. With COUNTER_HIST_SAT_EN → 0x3FFFF, o_ovf=1. Without it → 3, o_ovf=1. i_ovf_clr → o_ovf=0.
- Pulse i_clr_start with increments streaming → o_clr_busy for 4098 cycles, requests and reads during busy ignored, all bins 0 afterwards.
- Assert i_rstn=0 mid-clear at address 100 → clear restarts at 0, o_rd_valid=0, o_ovf=0 on the cycle after reset.
